// File: rtl/axi_reg_cut_pkg.sv
// -----------------------------------------------------------------------------
// axi_reg_cut_pkg
// Shared constants and channel-width helpers for the AXI4 register slice.
// The width functions return the packed payload width of each channel, so the
// slice, its spill registers and any wrapper agree on the same bit layouts:
//   AW/AR = {id, addr, len, size, burst, lock, cache, prot, qos, region, user}
//   W     = {data, strb, last, user}
//   B     = {id, resp, user}
//   R     = {id, data, resp, last, user}
// -----------------------------------------------------------------------------
package axi_reg_cut_pkg;

    localparam int LEN_W    = 8;
    localparam int SIZE_W   = 3;
    localparam int BURST_W  = 2;
    localparam int CACHE_W  = 4;
    localparam int PROT_W   = 3;
    localparam int QOS_W    = 4;
    localparam int REGION_W = 4;
    localparam int RESP_W   = 2;

    // Every width function takes the full parameter set so all call sites look
    // the same; parameters a channel does not carry are multiplied out by zero.

    function automatic int aw_width(input int addr_width, input int data_width,
                                    input int id_width, input int user_width);
        return id_width + addr_width + LEN_W + SIZE_W + BURST_W + 1 + CACHE_W
               + PROT_W + QOS_W + REGION_W + user_width + 0 * data_width;
    endfunction

    function automatic int w_width(input int addr_width, input int data_width,
                                   input int id_width, input int user_width);
        return data_width + data_width / 8 + 1 + user_width
               + 0 * (addr_width + id_width);
    endfunction

    function automatic int b_width(input int addr_width, input int data_width,
                                   input int id_width, input int user_width);
        return id_width + RESP_W + user_width + 0 * (addr_width + data_width);
    endfunction

    function automatic int r_width(input int addr_width, input int data_width,
                                   input int id_width, input int user_width);
        return id_width + data_width + RESP_W + 1 + user_width + 0 * addr_width;
    endfunction

endpackage

// File: rtl/axi_reg_cut_spill.sv
// -----------------------------------------------------------------------------
// axi_spill_reg
// Generic two-slot valid/ready register. Slot A drives the output, slot B
// catches the one beat that may arrive while the output is stalled, so both
// out_valid/out_data and in_ready come straight from flops.
// Ports:
//   clk_i, rst_ni   clock, asynchronous active-low reset
//   srst_i          synchronous soft reset (clears both slots)
//   in_valid/in_ready/in_data     upstream handshake and payload
//   out_valid/out_ready/out_data  downstream handshake and payload
// BYPASS=1 turns the block into plain wires.
// -----------------------------------------------------------------------------
module axi_spill_reg
    import axi_reg_cut_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter bit BYPASS = 1'b0
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             srst_i,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    if (BYPASS) begin : g_bypass

        // Clock and resets have no function in the wire-through variant.
        logic unused_s;
        assign unused_s  = clk_i ^ rst_ni ^ srst_i;

        assign out_valid = in_valid;
        assign out_data  = in_data;
        assign in_ready  = out_ready;

    end else begin : g_spill

        logic             a_full_r;
        logic             b_full_r;
        logic             ready_r;
        logic [WIDTH-1:0] a_data_r;
        logic [WIDTH-1:0] b_data_r;

        logic             a_full_s;
        logic             b_full_s;
        logic             ready_s;
        logic [WIDTH-1:0] a_data_s;
        logic [WIDTH-1:0] b_data_s;
        logic             in_fire_s;
        logic             out_fire_s;

        // Next-state for the two slots; B is only written when A is held.
        always_comb begin
            a_full_s   = a_full_r;
            b_full_s   = b_full_r;
            a_data_s   = a_data_r;
            b_data_s   = b_data_r;
            in_fire_s  = in_valid & ready_r;
            out_fire_s = a_full_r & out_ready;

            if (out_fire_s && b_full_r) begin
                // ready_r is low whenever B is full, so no input can collide here.
                a_data_s = b_data_r;
                a_full_s = 1'b1;
                b_full_s = 1'b0;
            end else if (in_fire_s && (!a_full_r || out_fire_s)) begin
                a_data_s = in_data;
                a_full_s = 1'b1;
            end else if (in_fire_s) begin
                b_data_s = in_data;
                b_full_s = 1'b1;
            end else if (out_fire_s) begin
                a_full_s = 1'b0;
            end else begin
                a_full_s = a_full_r;
            end

            ready_s = ~b_full_s;
        end

        // Slot state registers; in_ready gets its own flop so it is never
        // derived combinationally from the downstream handshake.
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                a_full_r <= 1'b0;
                b_full_r <= 1'b0;
                ready_r  <= 1'b1;
                a_data_r <= {WIDTH{1'b0}};
                b_data_r <= {WIDTH{1'b0}};
            end else if (srst_i) begin
                a_full_r <= 1'b0;
                b_full_r <= 1'b0;
                ready_r  <= 1'b1;
                a_data_r <= {WIDTH{1'b0}};
                b_data_r <= {WIDTH{1'b0}};
            end else begin
                a_full_r <= a_full_s;
                b_full_r <= b_full_s;
                ready_r  <= ready_s;
                a_data_r <= a_data_s;
                b_data_r <= b_data_s;
            end
        end

        assign out_valid = a_full_r;
        assign out_data  = a_data_r;
        assign in_ready  = ready_r;

    end

endmodule

// File: rtl/axi_reg_cut.sv
// -----------------------------------------------------------------------------
// axi_reg_cut
// Single-stage AXI4 register slice. Every channel passes through its own
// spill register, cutting all combinational paths between the slave-side
// port (slv_*) and the master-side port (mst_*). AW/W/AR flow slv -> mst,
// B/R flow mst -> slv. Payloads are packed channel vectors carried bit-exact.
// Ports:
//   clk_i, rst_ni                      clock, asynchronous active-low reset
//   slv_{aw,w,ar}_{valid_i,ready_o,_i} request channels from upstream master
//   slv_{b,r}_{valid_o,ready_i,_o}     response channels to upstream master
//   mst_{aw,w,ar}_{valid_o,ready_i,_o} request channels to downstream slave
//   mst_{b,r}_{valid_i,ready_o,_i}     response channels from downstream slave
// BYPASS=1 makes every channel a zero-latency wire.
// -----------------------------------------------------------------------------
module axi_reg_cut
    import axi_reg_cut_pkg::*;
#(
    parameter int ADDR_WIDTH = 64,
    parameter int DATA_WIDTH = 64,
    parameter int ID_WIDTH   = 4,
    parameter int USER_WIDTH = 1,
    parameter bit BYPASS     = 1'b0
) (
    input  logic clk_i,
    input  logic rst_ni,

    input  logic slv_aw_valid_i,
    output logic slv_aw_ready_o,
    input  logic [aw_width(ADDR_WIDTH, DATA_WIDTH, ID_WIDTH, USER_WIDTH)-1:0] slv_aw_i,
    input  logic slv_w_valid_i,
    output logic slv_w_ready_o,
    input  logic [w_width(ADDR_WIDTH, DATA_WIDTH, ID_WIDTH, USER_WIDTH)-1:0]  slv_w_i,
    output logic slv_b_valid_o,
    input  logic slv_b_ready_i,
    output logic [b_width(ADDR_WIDTH, DATA_WIDTH, ID_WIDTH, USER_WIDTH)-1:0]  slv_b_o,
    input  logic slv_ar_valid_i,
    output logic slv_ar_ready_o,
    input  logic [aw_width(ADDR_WIDTH, DATA_WIDTH, ID_WIDTH, USER_WIDTH)-1:0] slv_ar_i,
    output logic slv_r_valid_o,
    input  logic slv_r_ready_i,
    output logic [r_width(ADDR_WIDTH, DATA_WIDTH, ID_WIDTH, USER_WIDTH)-1:0]  slv_r_o,

    output logic mst_aw_valid_o,
    input  logic mst_aw_ready_i,
    output logic [aw_width(ADDR_WIDTH, DATA_WIDTH, ID_WIDTH, USER_WIDTH)-1:0] mst_aw_o,
    output logic mst_w_valid_o,
    input  logic mst_w_ready_i,
    output logic [w_width(ADDR_WIDTH, DATA_WIDTH, ID_WIDTH, USER_WIDTH)-1:0]  mst_w_o,
    input  logic mst_b_valid_i,
    output logic mst_b_ready_o,
    input  logic [b_width(ADDR_WIDTH, DATA_WIDTH, ID_WIDTH, USER_WIDTH)-1:0]  mst_b_i,
    output logic mst_ar_valid_o,
    input  logic mst_ar_ready_i,
    output logic [aw_width(ADDR_WIDTH, DATA_WIDTH, ID_WIDTH, USER_WIDTH)-1:0] mst_ar_o,
    input  logic mst_r_valid_i,
    output logic mst_r_ready_o,
    input  logic [r_width(ADDR_WIDTH, DATA_WIDTH, ID_WIDTH, USER_WIDTH)-1:0]  mst_r_i
);

    localparam int AX_W = aw_width(ADDR_WIDTH, DATA_WIDTH, ID_WIDTH, USER_WIDTH);
    localparam int W_W  = w_width(ADDR_WIDTH, DATA_WIDTH, ID_WIDTH, USER_WIDTH);
    localparam int B_W  = b_width(ADDR_WIDTH, DATA_WIDTH, ID_WIDTH, USER_WIDTH);
    localparam int R_W  = r_width(ADDR_WIDTH, DATA_WIDTH, ID_WIDTH, USER_WIDTH);

    // The slice exposes no soft-reset pin; the spill registers keep theirs
    // for reuse in blocks that do.
    logic srst_s;
    assign srst_s = 1'b0;

    axi_spill_reg #(.WIDTH(AX_W), .BYPASS(BYPASS)) u_aw (
        .clk_i(clk_i), .rst_ni(rst_ni), .srst_i(srst_s),
        .in_valid(slv_aw_valid_i), .in_ready(slv_aw_ready_o), .in_data(slv_aw_i),
        .out_valid(mst_aw_valid_o), .out_ready(mst_aw_ready_i), .out_data(mst_aw_o)
    );

    axi_spill_reg #(.WIDTH(W_W), .BYPASS(BYPASS)) u_w (
        .clk_i(clk_i), .rst_ni(rst_ni), .srst_i(srst_s),
        .in_valid(slv_w_valid_i), .in_ready(slv_w_ready_o), .in_data(slv_w_i),
        .out_valid(mst_w_valid_o), .out_ready(mst_w_ready_i), .out_data(mst_w_o)
    );

    // B and R travel back towards the upstream master.
    axi_spill_reg #(.WIDTH(B_W), .BYPASS(BYPASS)) u_b (
        .clk_i(clk_i), .rst_ni(rst_ni), .srst_i(srst_s),
        .in_valid(mst_b_valid_i), .in_ready(mst_b_ready_o), .in_data(mst_b_i),
        .out_valid(slv_b_valid_o), .out_ready(slv_b_ready_i), .out_data(slv_b_o)
    );

    axi_spill_reg #(.WIDTH(AX_W), .BYPASS(BYPASS)) u_ar (
        .clk_i(clk_i), .rst_ni(rst_ni), .srst_i(srst_s),
        .in_valid(slv_ar_valid_i), .in_ready(slv_ar_ready_o), .in_data(slv_ar_i),
        .out_valid(mst_ar_valid_o), .out_ready(mst_ar_ready_i), .out_data(mst_ar_o)
    );

    axi_spill_reg #(.WIDTH(R_W), .BYPASS(BYPASS)) u_r (
        .clk_i(clk_i), .rst_ni(rst_ni), .srst_i(srst_s),
        .in_valid(mst_r_valid_i), .in_ready(mst_r_ready_o), .in_data(mst_r_i),
        .out_valid(slv_r_valid_o), .out_ready(slv_r_ready_i), .out_data(slv_r_o)
    );

endmodule

// File: tb/tb_axi_reg_cut.sv
// -----------------------------------------------------------------------------
// tb_axi_reg_cut
// Self-checking bench for axi_reg_cut with default widths
// (AW/AR 98 bits, W 74 bits, B 7 bits, R 72 bits). Drivers push every accepted
// beat into a per-channel expected queue; a monitor pops and compares each
// delivered beat and checks that stalled outputs hold still. A second
// instance with BYPASS=1 is checked for wire-through behaviour.
// -----------------------------------------------------------------------------
module tb_axi_reg_cut;

    localparam int AXW = 98;
    localparam int WW  = 74;
    localparam int BW  = 7;
    localparam int RW  = 72;

    logic clk;
    logic rst_ni;

    logic slv_aw_valid_i, slv_aw_ready_o; logic [AXW-1:0] slv_aw_i;
    logic slv_w_valid_i,  slv_w_ready_o;  logic [WW-1:0]  slv_w_i;
    logic slv_b_valid_o,  slv_b_ready_i;  logic [BW-1:0]  slv_b_o;
    logic slv_ar_valid_i, slv_ar_ready_o; logic [AXW-1:0] slv_ar_i;
    logic slv_r_valid_o,  slv_r_ready_i;  logic [RW-1:0]  slv_r_o;
    logic mst_aw_valid_o, mst_aw_ready_i; logic [AXW-1:0] mst_aw_o;
    logic mst_w_valid_o,  mst_w_ready_i;  logic [WW-1:0]  mst_w_o;
    logic mst_b_valid_i,  mst_b_ready_o;  logic [BW-1:0]  mst_b_i;
    logic mst_ar_valid_o, mst_ar_ready_i; logic [AXW-1:0] mst_ar_o;
    logic mst_r_valid_i,  mst_r_ready_o;  logic [RW-1:0]  mst_r_i;

    // bypass instance signals
    logic b_aw_v, b_aw_r, b_aw_mv, b_aw_mr; logic [AXW-1:0] b_aw_d, b_aw_md;
    logic b_w_v,  b_w_r,  b_w_mv,  b_w_mr;  logic [WW-1:0]  b_w_d,  b_w_md;
    logic b_b_v,  b_b_r,  b_b_mv,  b_b_mr;  logic [BW-1:0]  b_b_d,  b_b_md;
    logic b_ar_v, b_ar_r, b_ar_mv, b_ar_mr; logic [AXW-1:0] b_ar_d, b_ar_md;
    logic b_r_v,  b_r_r,  b_r_mv,  b_r_mr;  logic [RW-1:0]  b_r_d,  b_r_md;

    axi_reg_cut dut (
        .clk_i(clk), .rst_ni(rst_ni),
        .slv_aw_valid_i(slv_aw_valid_i), .slv_aw_ready_o(slv_aw_ready_o), .slv_aw_i(slv_aw_i),
        .slv_w_valid_i(slv_w_valid_i),   .slv_w_ready_o(slv_w_ready_o),   .slv_w_i(slv_w_i),
        .slv_b_valid_o(slv_b_valid_o),   .slv_b_ready_i(slv_b_ready_i),   .slv_b_o(slv_b_o),
        .slv_ar_valid_i(slv_ar_valid_i), .slv_ar_ready_o(slv_ar_ready_o), .slv_ar_i(slv_ar_i),
        .slv_r_valid_o(slv_r_valid_o),   .slv_r_ready_i(slv_r_ready_i),   .slv_r_o(slv_r_o),
        .mst_aw_valid_o(mst_aw_valid_o), .mst_aw_ready_i(mst_aw_ready_i), .mst_aw_o(mst_aw_o),
        .mst_w_valid_o(mst_w_valid_o),   .mst_w_ready_i(mst_w_ready_i),   .mst_w_o(mst_w_o),
        .mst_b_valid_i(mst_b_valid_i),   .mst_b_ready_o(mst_b_ready_o),   .mst_b_i(mst_b_i),
        .mst_ar_valid_o(mst_ar_valid_o), .mst_ar_ready_i(mst_ar_ready_i), .mst_ar_o(mst_ar_o),
        .mst_r_valid_i(mst_r_valid_i),   .mst_r_ready_o(mst_r_ready_o),   .mst_r_i(mst_r_i)
    );

    axi_reg_cut #(.BYPASS(1'b1)) dut_byp (
        .clk_i(clk), .rst_ni(rst_ni),
        .slv_aw_valid_i(b_aw_v), .slv_aw_ready_o(b_aw_r), .slv_aw_i(b_aw_d),
        .slv_w_valid_i(b_w_v),   .slv_w_ready_o(b_w_r),   .slv_w_i(b_w_d),
        .slv_b_valid_o(b_b_v),   .slv_b_ready_i(b_b_r),   .slv_b_o(b_b_d),
        .slv_ar_valid_i(b_ar_v), .slv_ar_ready_o(b_ar_r), .slv_ar_i(b_ar_d),
        .slv_r_valid_o(b_r_v),   .slv_r_ready_i(b_r_r),   .slv_r_o(b_r_d),
        .mst_aw_valid_o(b_aw_mv), .mst_aw_ready_i(b_aw_mr), .mst_aw_o(b_aw_md),
        .mst_w_valid_o(b_w_mv),   .mst_w_ready_i(b_w_mr),   .mst_w_o(b_w_md),
        .mst_b_valid_i(b_b_mv),   .mst_b_ready_o(b_b_mr),   .mst_b_i(b_b_md),
        .mst_ar_valid_o(b_ar_mv), .mst_ar_ready_i(b_ar_mr), .mst_ar_o(b_ar_md),
        .mst_r_valid_i(b_r_mv),   .mst_r_ready_o(b_r_mr),   .mst_r_i(b_r_md)
    );

    int checks = 0;
    int errors = 0;

    // channel index: 0 AW, 1 W, 2 B, 3 AR, 4 R
    logic [127:0] exp_q [5][$];
    logic         prev_stall [5];
    logic [127:0] prev_data  [5];
    logic         hold [5];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic push(input int ch, input logic [127:0] d);
        exp_q[ch].push_back(d);
    endtask

    // Monitor: compare each delivered beat against the queue, check stall stability.
    task automatic mon_chan(input int ch, input string name, input logic v,
                            input logic r, input logic [127:0] d);
        logic [127:0] e;
        if (prev_stall[ch]) begin
            checks++;
            if (!v || d !== prev_data[ch]) begin
                errors++;
                $display("FAIL %s_stable: got valid %b data %h expected valid 1 data %h",
                         name, v, d, prev_data[ch]);
            end
        end
        if (v && r) begin
            checks++;
            if (exp_q[ch].size() == 0) begin
                errors++;
                $display("FAIL %s_unexpected: got beat %h expected none", name, d);
            end else begin
                e = exp_q[ch].pop_front();
                if (d !== e) begin
                    errors++;
                    $display("FAIL %s_order: got %h expected %h", name, d, e);
                end
            end
        end
        prev_stall[ch] = v & ~r;
        prev_data[ch]  = d;
    endtask

    always @(negedge clk) begin
        #2;
        if (!rst_ni) begin
            for (int c = 0; c < 5; c++) prev_stall[c] = 1'b0;
        end else begin
            mon_chan(0, "aw", mst_aw_valid_o, mst_aw_ready_i, 128'(mst_aw_o));
            mon_chan(1, "w",  mst_w_valid_o,  mst_w_ready_i,  128'(mst_w_o));
            mon_chan(2, "b",  slv_b_valid_o,  slv_b_ready_i,  128'(slv_b_o));
            mon_chan(3, "ar", mst_ar_valid_o, mst_ar_ready_i, 128'(mst_ar_o));
            mon_chan(4, "r",  slv_r_valid_o,  slv_r_ready_i,  128'(slv_r_o));
        end
    end

    task automatic idle_inputs();
        slv_aw_valid_i = 1'b0; slv_w_valid_i = 1'b0; slv_ar_valid_i = 1'b0;
        mst_b_valid_i  = 1'b0; mst_r_valid_i = 1'b0;
        mst_aw_ready_i = 1'b1; mst_w_ready_i = 1'b1; mst_ar_ready_i = 1'b1;
        slv_b_ready_i  = 1'b1; slv_r_ready_i = 1'b1;
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_aw_valid"}, 128'(mst_aw_valid_o), 128'd0);
        chk({tag, "_w_valid"},  128'(mst_w_valid_o),  128'd0);
        chk({tag, "_b_valid"},  128'(slv_b_valid_o),  128'd0);
        chk({tag, "_ar_valid"}, 128'(mst_ar_valid_o), 128'd0);
        chk({tag, "_r_valid"},  128'(slv_r_valid_o),  128'd0);
        chk({tag, "_aw_ready"}, 128'(slv_aw_ready_o), 128'd1);
        chk({tag, "_w_ready"},  128'(slv_w_ready_o),  128'd1);
        chk({tag, "_b_ready"},  128'(mst_b_ready_o),  128'd1);
        chk({tag, "_ar_ready"}, 128'(slv_ar_ready_o), 128'd1);
        chk({tag, "_r_ready"},  128'(mst_r_ready_o),  128'd1);
    endtask

    // One cycle of random traffic on all five channels, AXI-legal on the input side.
    task automatic rand_step();
        logic [127:0] r;
        @(negedge clk);
        if (!hold[0]) begin r = rnd128(); slv_aw_valid_i = 1'($urandom_range(0, 1)); slv_aw_i = r[AXW-1:0]; end
        if (!hold[1]) begin r = rnd128(); slv_w_valid_i  = 1'($urandom_range(0, 1)); slv_w_i  = r[WW-1:0];  end
        if (!hold[2]) begin r = rnd128(); mst_b_valid_i  = 1'($urandom_range(0, 1)); mst_b_i  = r[BW-1:0];  end
        if (!hold[3]) begin r = rnd128(); slv_ar_valid_i = 1'($urandom_range(0, 1)); slv_ar_i = r[AXW-1:0]; end
        if (!hold[4]) begin r = rnd128(); mst_r_valid_i  = 1'($urandom_range(0, 1)); mst_r_i  = r[RW-1:0];  end
        mst_aw_ready_i = ($urandom_range(0, 3) != 0);
        mst_w_ready_i  = ($urandom_range(0, 1) != 0);
        slv_b_ready_i  = ($urandom_range(0, 3) != 0);
        mst_ar_ready_i = ($urandom_range(0, 2) != 0);
        slv_r_ready_i  = ($urandom_range(0, 3) == 0);
        if (slv_aw_valid_i && slv_aw_ready_o) push(0, 128'(slv_aw_i));
        if (slv_w_valid_i  && slv_w_ready_o)  push(1, 128'(slv_w_i));
        if (mst_b_valid_i  && mst_b_ready_o)  push(2, 128'(mst_b_i));
        if (slv_ar_valid_i && slv_ar_ready_o) push(3, 128'(slv_ar_i));
        if (mst_r_valid_i  && mst_r_ready_o)  push(4, 128'(mst_r_i));
        hold[0] = slv_aw_valid_i & ~slv_aw_ready_o;
        hold[1] = slv_w_valid_i  & ~slv_w_ready_o;
        hold[2] = mst_b_valid_i  & ~mst_b_ready_o;
        hold[3] = slv_ar_valid_i & ~slv_ar_ready_o;
        hold[4] = mst_r_valid_i  & ~mst_r_ready_o;
    endtask

    initial begin
        logic [AXW-1:0] aw_exp;
        logic [AXW-1:0] ar_byp;
        logic [RW-1:0]  r_first;
        logic [127:0]   r;
        int acc;

        for (int c = 0; c < 5; c++) begin hold[c] = 1'b0; prev_stall[c] = 1'b0; end
        b_aw_v = 1'b0; b_aw_d = '0; b_aw_mr = 1'b0;
        b_w_v = 1'b0;  b_w_d = '0;  b_w_mr = 1'b0;
        b_b_r = 1'b0;  b_b_mv = 1'b0; b_b_md = '0;
        b_ar_v = 1'b0; b_ar_d = '0; b_ar_mr = 1'b0;
        b_r_r = 1'b0;  b_r_mv = 1'b0; b_r_md = '0;
        slv_aw_i = '0; slv_w_i = '0; slv_ar_i = '0; mst_b_i = '0; mst_r_i = '0;
        idle_inputs();

        // Reset held with random traffic on every input.
        rst_ni = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            r = rnd128();
            {slv_aw_valid_i, slv_w_valid_i, mst_b_valid_i, slv_ar_valid_i, mst_r_valid_i} = r[4:0];
            {mst_aw_ready_i, mst_w_ready_i, slv_b_ready_i, mst_ar_ready_i, slv_r_ready_i} = r[9:5];
            slv_aw_i = r[AXW-1:0]; slv_ar_i = r[AXW+9:10]; slv_w_i = r[WW+3:4];
            mst_b_i = r[BW+20:21]; mst_r_i = r[RW+30:31];
        end
        #3;
        check_idle("rst");
        @(negedge clk);
        idle_inputs();
        rst_ni = 1'b1;
        @(negedge clk);
        #3;
        check_idle("post_rst");

        // Single AW beat: visible exactly one cycle later, for one cycle.
        aw_exp = {4'd3, 64'h1000, 8'd7, 3'd0, 2'd0, 1'b0, 4'd0, 3'd0, 4'd0, 4'd0, 1'b0};
        @(negedge clk);
        slv_aw_valid_i = 1'b1; slv_aw_i = aw_exp;
        if (slv_aw_valid_i && slv_aw_ready_o) push(0, 128'(slv_aw_i));
        #3;
        chk("aw_not_zero_latency", 128'(mst_aw_valid_o), 128'd0);
        @(negedge clk);
        slv_aw_valid_i = 1'b0;
        #3;
        chk("aw_valid_lat1", 128'(mst_aw_valid_o), 128'd1);
        chk("aw_payload", 128'(mst_aw_o), 128'(aw_exp));
        @(negedge clk);
        #3;
        chk("aw_single_cycle", 128'(mst_aw_valid_o), 128'd0);

        // Back-to-back W: 16 beats with both sides ready.
        for (int i = 0; i <= 16; i++) begin
            @(negedge clk);
            if (i < 16) begin
                chk("w_in_ready", 128'(slv_w_ready_o), 128'd1);
                slv_w_valid_i = 1'b1;
                slv_w_i = {64'(i), 8'hFF, 1'(i == 15), 1'b0};
                if (slv_w_valid_i && slv_w_ready_o) push(1, 128'(slv_w_i));
            end else begin
                slv_w_valid_i = 1'b0;
            end
            #3;
            if (i > 0) begin
                chk("w_stream_valid", 128'(mst_w_valid_o), 128'd1);
                chk("w_last", 128'(mst_w_o[1]), 128'(i == 16));
            end
        end
        @(negedge clk);
        #3;
        chk("w_stream_end", 128'(mst_w_valid_o), 128'd0);

        // R backpressure: only two beats fit before mst_r_ready_o drops.
        slv_r_ready_i = 1'b0;
        acc = 0;
        r_first = {4'd0, 64'hA0, 2'd0, 1'b0, 1'b0};
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            mst_r_valid_i = 1'b1;
            mst_r_i = {4'd0, 64'(8'hA0 + acc), 2'd0, 1'b0, 1'b0};
            if (mst_r_valid_i && mst_r_ready_o) begin
                push(4, 128'(mst_r_i));
                acc++;
            end
        end
        @(negedge clk);
        mst_r_valid_i = 1'b0;
        #3;
        chk("r_accepted", 128'(acc), 128'd2);
        chk("r_ready_low", 128'(mst_r_ready_o), 128'd0);
        chk("r_head_held", 128'(slv_r_o), 128'(r_first));
        @(negedge clk);
        slv_r_ready_i = 1'b1;
        for (int k = 0; k < 4; k++) @(negedge clk);
        #3;
        chk("r_drained", 128'(exp_q[4].size()), 128'd0);
        chk("r_ready_back", 128'(mst_r_ready_o), 128'd1);

        // Bypass instance: pure wires.
        ar_byp = {4'd0, 64'hDEAD_BEEF, 30'd0};
        b_ar_v = 1'b1; b_ar_d = ar_byp; b_ar_mr = 1'b0;
        #1;
        chk("byp_ar_data", 128'(b_ar_md), 128'(ar_byp));
        chk("byp_ar_valid", 128'(b_ar_mv), 128'd1);
        chk("byp_ar_ready0", 128'(b_ar_r), 128'd0);
        b_ar_mr = 1'b1;
        #1;
        chk("byp_ar_ready1", 128'(b_ar_r), 128'd1);
        b_r_mv = 1'b1; b_r_md = {4'd5, 64'h1234, 2'd1, 1'b1, 1'b0}; b_r_r = 1'b1;
        #1;
        chk("byp_r_data", 128'(b_r_d), 128'({4'd5, 64'h1234, 2'd1, 1'b1, 1'b0}));
        chk("byp_r_ready", 128'(b_r_mr), 128'd1);

        // Random concurrent traffic on all channels.
        for (int i = 0; i < 10000; i++) rand_step();

        // Drain and confirm nothing was lost.
        @(negedge clk);
        idle_inputs();
        for (int i = 0; i < 6; i++) @(negedge clk);
        #3;
        chk("aw_q_empty", 128'(exp_q[0].size()), 128'd0);
        chk("w_q_empty",  128'(exp_q[1].size()), 128'd0);
        chk("b_q_empty",  128'(exp_q[2].size()), 128'd0);
        chk("ar_q_empty", 128'(exp_q[3].size()), 128'd0);
        chk("r_q_empty",  128'(exp_q[4].size()), 128'd0);
        check_idle("final");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/axi_reg_cut.md
Name: axi_reg_cut

Overview:
- Single-stage AXI4 register slice for long interconnect paths.
- Breaks every combinational path between the slave-side port (slv_*) and the master-side port (mst_*) on all five channels: AW, W, B, AR, R.
- Each channel gets its own two-entry spill register, so valid, ready and payload are all registered in both directions.
- Chains of instances form multi-cut links; BYPASS=1 degenerates to plain wires.

Parameters:
- ADDR_WIDTH, 64, address width of AW/AR.
- DATA_WIDTH, 64, data width of W/R; strobe width is DATA_WIDTH/8.
- ID_WIDTH, 4, transaction ID width.
- USER_WIDTH, 1, user-signal width on all channels.
- BYPASS, 0, 1 = pure combinational pass-through, no registers.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous active-low reset.
- Each payload below is a packed channel vector; widths come from the package functions.
- slv_aw_valid_i in 1 / slv_aw_ready_o out 1 / slv_aw_i in AW_W  AW from upstream master.
- slv_w_valid_i in 1 / slv_w_ready_o out 1 / slv_w_i in W_W  W from upstream.
- slv_b_valid_o out 1 / slv_b_ready_i in 1 / slv_b_o out B_W  B to upstream.
- slv_ar_valid_i in 1 / slv_ar_ready_o out 1 / slv_ar_i in AR_W  AR from upstream.
- slv_r_valid_o out 1 / slv_r_ready_i in 1 / slv_r_o out R_W  R to upstream.
- mst_aw_valid_o out 1 / mst_aw_ready_i in 1 / mst_aw_o out AW_W  AW downstream.
- mst_w_valid_o out 1 / mst_w_ready_i in 1 / mst_w_o out W_W  W downstream.
- mst_b_valid_i in 1 / mst_b_ready_o out 1 / mst_b_i in B_W  B from downstream.
- mst_ar_valid_o out 1 / mst_ar_ready_i in 1 / mst_ar_o out AR_W  AR downstream.
- mst_r_valid_i in 1 / mst_r_ready_o out 1 / mst_r_i in R_W  R from downstream.

Behaviour:
- Payload bit layouts, MSB→LSB:
  - AW/AR = {id, addr, len[8], size[3], burst[2], lock, cache[4], prot[3], qos[4], region[4], user}.
  - W = {data, strb, last, user}.
  - B = {id, resp[2], user}.
  - R = {id, data, resp[2], last, user}.
- The module never inspects payload; it transports it bit-exact.
- Channels are fully independent; there is no cross-channel ordering or coupling.
- Spill register, one per channel (forward direction for AW/W/AR, reverse direction for B/R):
  - Slots A (output) and B (overflow), each with a full flag.
  - out_valid = A_full; out_data = A_data.
  - in_ready = !B_full, driven from a flop.
  - Input accepted (in_valid & in_ready):
    - if A empty, or A drains in the same cycle while B is empty → write A;
    - otherwise → write B.
  - Output consumed (out_valid & out_ready) with B full → B moves to A, B clears.
  - Consumed with B empty and no new input → A clears.
- Timing:
  - Latency 1 cycle from accepted input to out_valid.
  - Sustained throughput 1 beat/cycle with out_ready held high.
  - Stall absorption: after downstream ready drops, at most 2 beats are held; in_ready falls the cycle after B fills.
- Ordering: strict FIFO per channel; no beat is dropped or duplicated; payload is stable while valid & !ready.
- Reset (async assert, rst_ni=0):
  - all full flags = 0, so every *_valid_o = 0 and every *_ready_o = 1;
  - data flops reset to 0.
  - Reset mid-transfer discards held beats.
- BYPASS=1:
  - mst_x = slv_x, mst_x_valid = slv_x_valid, slv_x_ready = mst_x_ready (and the mirror for B/R);
  - zero latency, no flops.

Decomposition:
- Package axi_reg_cut_pkg holds:
  - constants LEN_W=8, SIZE_W=3, BURST_W=2, CACHE_W=4, PROT_W=3, QOS_W=4, REGION_W=4, RESP_W=2;
  - functions aw_width/w_width/b_width/r_width(ADDR_WIDTH, DATA_WIDTH, ID_WIDTH, USER_WIDTH).
- One sub-module, axi_spill_reg #(WIDTH, BYPASS): generic two-slot valid/ready register, instantiated five times.

Test Plan:
- Reset: hold rst_ni=0 with random inputs → all 5 *_valid_o = 0 and all 5 *_ready_o = 1. Release → same until stimulus arrives.
- Single AW: drive slv_aw_valid_i=1 with id=3, addr=0x1000, len=7 for one cycle, mst ready=1 → mst_aw_valid_o=1 exactly the next cycle with identical payload, for one cycle.
- Back-to-back W: stream 16 beats data=0..15, last on beat 15, both sides always ready → 16 consecutive output beats, 1-cycle latency, last only on beat 15.
- Backpressure: stream R beats 0xA0.. with slv_r_ready_i=0 → exactly 2 beats accepted, then mst_r_ready_o=0. Raise ready → beats emerge 0xA0, 0xA1, … in order, none lost.
- Random valid/ready on all five channels concurrently, 10k cycles → scoreboard per channel shows bit-exact in-order delivery; payload stable while valid & !ready.
- BYPASS=1: apply AR addr=0xDEAD_BEEF → mst_ar_o equals the input in the same cycle, and slv_ar_ready_o tracks mst_ar_ready_i combinationally.
